// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: one FSM owns the mm:ss countdown and the magnetron duty cycle.
// Optional macro QUICK_START_EN: start at 00:00 quick-starts 00:30 at full power; start in COOK adds 30 s.
module cook_sequencer #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned DUTY_WINDOW = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       time_load,
    input  logic [6:0] load_min,
    input  logic [5:0] load_sec,
    input  logic [3:0] power_level,
    output logic       magnetron_en,
    output logic       cooking,
    output logic       paused,
    output logic       done,
    output logic [6:0] rem_min,
    output logic [5:0] rem_sec
);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DUTY_WINDOW > 1) ? $clog2(DUTY_WINDOW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSE, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [6:0]    r_min, w_min_nxt, w_base_min, w_dec_min, w_ld_min;
    logic [5:0]    r_sec, w_sec_nxt, w_base_sec, w_dec_sec, w_ld_sec;
    logic [TW-1:0] r_tick, w_tick_nxt;
    logic [DW-1:0] r_dsec, w_dsec_nxt;
    logic          r_start_d, r_stop_d, r_clear_d;
    logic          r_quick, w_quick_nxt;
    logic          w_start_edge, w_stop_edge, w_clear_edge;
    logic          w_time_zero, w_tick_wrap, w_dsec_wrap, w_duty_on;
    logic [3:0]    w_pwr;

    assign w_start_edge = start & ~r_start_d;
    assign w_stop_edge  = stop & ~r_stop_d;
    assign w_clear_edge = clear & ~r_clear_d;
    assign w_time_zero  = (r_min == '0) && (r_sec == '0);
    assign w_tick_wrap  = (r_tick == TW'(TICK_DIV - 1));
    assign w_dsec_wrap  = (r_dsec == DW'(DUTY_WINDOW - 1));
    assign w_ld_min     = (load_min > 7'd99) ? 7'd99 : load_min;
    assign w_ld_sec     = (load_sec > 6'd59) ? 6'd59 : load_sec;
    assign w_pwr        = (r_quick || power_level == 4'd0 || power_level > 4'd10) ? 4'd10 : power_level;
    assign w_duty_on    = 32'(w_dsec_nxt) < 32'(w_pwr);

    assign rem_min = r_min;
    assign rem_sec = r_sec;

    // Base time (optionally +30 s, saturating) followed by the one-second borrow decrement.
    always_comb begin
        w_base_min = r_min;
        w_base_sec = r_sec;
`ifdef QUICK_START_EN
        if (w_start_edge) begin
            if (r_sec >= 6'd30) begin
                if (r_min >= 7'd99) begin
                    w_base_min = 7'd99;
                    w_base_sec = 6'd59;
                end else begin
                    w_base_min = r_min + 7'd1;
                    w_base_sec = r_sec - 6'd30;
                end
            end else begin
                w_base_sec = r_sec + 6'd30;
            end
        end
`endif
        w_dec_min = w_base_min;
        w_dec_sec = w_base_sec;
        if (w_base_sec != '0) begin
            w_dec_sec = w_base_sec - 6'd1;
        end else if (w_base_min != '0) begin
            w_dec_min = w_base_min - 7'd1;
            w_dec_sec = 6'd59;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_tick_nxt  = r_tick;
        w_dsec_nxt  = r_dsec;
        w_quick_nxt = r_quick;
        if (w_clear_edge) begin
            w_state_nxt = S_IDLE;
            w_min_nxt   = '0;
            w_sec_nxt   = '0;
            w_quick_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (time_load) begin
                        w_min_nxt   = w_ld_min;
                        w_sec_nxt   = w_ld_sec;
                        w_quick_nxt = 1'b0;
                    end else if (!w_stop_edge && door_closed && w_start_edge) begin
                        if (!w_time_zero) begin
                            w_state_nxt = S_COOK;
                            w_tick_nxt  = '0;
                            w_dsec_nxt  = '0;
                        end
`ifdef QUICK_START_EN
                        else begin
                            w_state_nxt = S_COOK;
                            w_tick_nxt  = '0;
                            w_dsec_nxt  = '0;
                            w_min_nxt   = '0;
                            w_sec_nxt   = 6'd30;
                            w_quick_nxt = 1'b1;
                        end
`endif
                    end
                end
                S_COOK: begin
                    if (w_stop_edge || !door_closed) begin
                        w_state_nxt = S_PAUSE;
                    end else if (w_tick_wrap) begin
                        w_tick_nxt = '0;
                        w_dsec_nxt = w_dsec_wrap ? '0 : r_dsec + DW'(1);
                        w_min_nxt  = w_dec_min;
                        w_sec_nxt  = w_dec_sec;
                        if (w_dec_min == '0 && w_dec_sec == '0)
                            w_state_nxt = S_DONE;
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                        w_min_nxt  = w_base_min;
                        w_sec_nxt  = w_base_sec;
                    end
                end
                S_PAUSE: begin
                    if (w_stop_edge) begin
                        w_state_nxt = S_IDLE;
                        w_min_nxt   = '0;
                        w_sec_nxt   = '0;
                    end else if (door_closed && w_start_edge) begin
                        w_state_nxt = S_COOK;
                    end
                end
                S_DONE: begin
                    if (time_load) begin
                        w_state_nxt = S_IDLE;
                        w_min_nxt   = w_ld_min;
                        w_sec_nxt   = w_ld_sec;
                        w_quick_nxt = 1'b0;
                    end else if (!w_stop_edge && !door_closed) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_min        <= '0;
            r_sec        <= '0;
            r_tick       <= '0;
            r_dsec       <= '0;
            r_quick      <= 1'b0;
            r_start_d    <= 1'b0;
            r_stop_d     <= 1'b0;
            r_clear_d    <= 1'b0;
            magnetron_en <= 1'b0;
            cooking      <= 1'b0;
            paused       <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_min        <= w_min_nxt;
            r_sec        <= w_sec_nxt;
            r_tick       <= w_tick_nxt;
            r_dsec       <= w_dsec_nxt;
            r_quick      <= w_quick_nxt;
            r_start_d    <= start;
            r_stop_d     <= stop;
            r_clear_d    <= clear;
            magnetron_en <= (w_state_nxt == S_COOK) && door_closed && w_duty_on;
            cooking      <= (w_state_nxt == S_COOK);
            paused       <= (w_state_nxt == S_PAUSE);
            done         <= (w_state_nxt == S_DONE);
        end
    end
endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer (TICK_DIV=4, DUTY_WINDOW=10); define QUICK_START_EN to cover quick start.
module tb_cook_sequencer;
    logic       clk, reset, start, stop, clear, door_closed, time_load;
    logic [6:0] load_min;
    logic [5:0] load_sec;
    logic [3:0] power_level;
    logic       magnetron_en, cooking, paused, done;
    logic [6:0] rem_min;
    logic [5:0] rem_sec;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [12:0] exp_q[$];
    logic [12:0] exp_t;

    cook_sequencer #(.TICK_DIV(4), .DUTY_WINDOW(10)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .door_closed(door_closed), .time_load(time_load), .load_min(load_min),
        .load_sec(load_sec), .power_level(power_level), .magnetron_en(magnetron_en),
        .cooking(cooking), .paused(paused), .done(done), .rem_min(rem_min), .rem_sec(rem_sec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_time(input logic [6:0] m, input logic [5:0] s);
        load_min = m; load_sec = s; time_load = 1'b1;
        step(1);
        time_load = 1'b0;
    endtask

    task automatic pulse_start; start = 1'b1; step(1); start = 1'b0; endtask
    task automatic pulse_stop;  stop  = 1'b1; step(1); stop  = 1'b0; endtask
    task automatic pulse_clear; clear = 1'b1; step(1); clear = 1'b0; endtask

    task automatic test_reset;
        reset = 1'b1;
        step(2);
        n_tests++;
        if ({magnetron_en, cooking, paused, done, rem_min, rem_sec} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h required 0", {magnetron_en, cooking, paused, done, rem_min, rem_sec});
        end
        reset = 1'b0;
        step(1);
        n_tests++;
        if ({magnetron_en, cooking, paused, done, rem_min, rem_sec} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h required 0", {magnetron_en, cooking, paused, done, rem_min, rem_sec});
        end
    endtask

    task automatic test_countdown;
        power_level = 4'd10;
        load_time(7'd0, 6'd3);
        exp_q.push_back({7'd0, 6'd3});
        n_tests++; exp_t = exp_q.pop_front();
        if ({rem_min, rem_sec} !== exp_t) begin
            n_fail++; $display("FAIL cd_load: got %0d:%0d required %0d:%0d", rem_min, rem_sec, exp_t[12:6], exp_t[5:0]);
        end
        pulse_start();
        n_tests++;
        if ({cooking, paused, done, magnetron_en} !== 4'b1001) begin
            n_fail++; $display("FAIL cd_enter: flags got %b required 1001", {cooking, paused, done, magnetron_en});
        end
        for (int i = 2; i >= 0; i--) exp_q.push_back({7'd0, 6'(i)});
        for (int i = 0; i < 3; i++) begin
            step(3);
            n_tests++;
            if ({cooking, paused, done, magnetron_en} !== 4'b1001) begin
                n_fail++; $display("FAIL cd_run%0d: flags got %b required 1001", i, {cooking, paused, done, magnetron_en});
            end
            step(1);
            n_tests++; exp_t = exp_q.pop_front();
            if ({rem_min, rem_sec} !== exp_t) begin
                n_fail++; $display("FAIL cd_tick%0d: got %0d:%0d required %0d:%0d", i, rem_min, rem_sec, exp_t[12:6], exp_t[5:0]);
            end
        end
        n_tests++;
        if ({cooking, paused, done, magnetron_en} !== 4'b0010) begin
            n_fail++; $display("FAIL cd_done: flags got %b required 0010", {cooking, paused, done, magnetron_en});
        end
        load_time(7'd0, 6'd4);
        exp_q.push_back({7'd0, 6'd4});
        n_tests++; exp_t = exp_q.pop_front();
        if ({cooking, paused, done, magnetron_en, rem_min, rem_sec} !== {4'b0000, exp_t}) begin
            n_fail++; $display("FAIL done_load: got %b %0d:%0d required 0000 00:04", {cooking, paused, done, magnetron_en}, rem_min, rem_sec);
        end
        pulse_clear();
    endtask

    task automatic test_borrow_clamp;
        load_time(7'd1, 6'd0);
        pulse_start();
        step(4);
        exp_q.push_back({7'd0, 6'd59});
        n_tests++; exp_t = exp_q.pop_front();
        if ({rem_min, rem_sec} !== exp_t) begin
            n_fail++; $display("FAIL borrow: got %0d:%0d required 0:59", rem_min, rem_sec);
        end
        load_time(7'd0, 6'd7);
        exp_q.push_back({7'd0, 6'd59});
        n_tests++; exp_t = exp_q.pop_front();
        if ({cooking, rem_min, rem_sec} !== {1'b1, exp_t}) begin
            n_fail++; $display("FAIL load_in_cook: got c=%b %0d:%0d required c=1 0:59", cooking, rem_min, rem_sec);
        end
        pulse_clear();
        load_time(7'd120, 6'd63);
        exp_q.push_back({7'd99, 6'd59});
        n_tests++; exp_t = exp_q.pop_front();
        if ({rem_min, rem_sec} !== exp_t) begin
            n_fail++; $display("FAIL clamp_a: got %0d:%0d required 99:59", rem_min, rem_sec);
        end
        load_time(7'd99, 6'd60);
        exp_q.push_back({7'd99, 6'd59});
        n_tests++; exp_t = exp_q.pop_front();
        if ({rem_min, rem_sec} !== exp_t) begin
            n_fail++; $display("FAIL clamp_b: got %0d:%0d required 99:59", rem_min, rem_sec);
        end
        pulse_clear();
    endtask

    task automatic test_duty;
        logic exp_mag;
        power_level = 4'd3;
        load_time(7'd0, 6'd20);
        pulse_start();
        for (int k = 0; k < 80; k++) begin
            exp_mag = (((k / 4) % 10) < 3);
            n_tests++;
            if (magnetron_en !== exp_mag) begin
                n_fail++; $display("FAIL duty_k%0d: magnetron_en got %b required %b", k, magnetron_en, exp_mag);
            end
            step(1);
        end
        n_tests++;
        if ({cooking, paused, done, magnetron_en, rem_min, rem_sec} !== {4'b0010, 13'd0}) begin
            n_fail++; $display("FAIL duty_end: got %b %0d:%0d required 0010 0:0", {cooking, paused, done, magnetron_en}, rem_min, rem_sec);
        end
        power_level = 4'd10;
        pulse_clear();
    endtask

    task automatic test_door;
        load_time(7'd0, 6'd10);
        pulse_start();
        step(5);
        door_closed = 1'b0;
        step(1);
        n_tests++;
        if ({cooking, paused, done, magnetron_en} !== 4'b0100) begin
            n_fail++; $display("FAIL door_open: flags got %b required 0100", {cooking, paused, done, magnetron_en});
        end
        step(8);
        exp_q.push_back({7'd0, 6'd9});
        n_tests++; exp_t = exp_q.pop_front();
        if ({rem_min, rem_sec} !== exp_t) begin
            n_fail++; $display("FAIL door_frozen: got %0d:%0d required 0:9", rem_min, rem_sec);
        end
        pulse_start();
        step(1);
        n_tests++;
        if ({cooking, paused, done, magnetron_en, rem_min, rem_sec} !== {4'b0100, 7'd0, 6'd9}) begin
            n_fail++; $display("FAIL door_open_start: got %b %0d:%0d required 0100 0:9", {cooking, paused, done, magnetron_en}, rem_min, rem_sec);
        end
        door_closed = 1'b1;
        step(1);
        n_tests++;
        if ({cooking, paused, done, magnetron_en} !== 4'b0100) begin
            n_fail++; $display("FAIL door_close_only: flags got %b required 0100", {cooking, paused, done, magnetron_en});
        end
        pulse_start();
        n_tests++;
        if ({cooking, paused, done, magnetron_en} !== 4'b1001) begin
            n_fail++; $display("FAIL resume: flags got %b required 1001", {cooking, paused, done, magnetron_en});
        end
        exp_q.push_back({7'd0, 6'd9});
        exp_q.push_back({7'd0, 6'd8});
        step(1);
        n_tests++; exp_t = exp_q.pop_front();
        if ({rem_min, rem_sec} !== exp_t) begin
            n_fail++; $display("FAIL resume_hold: got %0d:%0d required 0:9", rem_min, rem_sec);
        end
        step(2);
        n_tests++; exp_t = exp_q.pop_front();
        if ({rem_min, rem_sec} !== exp_t) begin
            n_fail++; $display("FAIL resume_tick: got %0d:%0d required 0:8", rem_min, rem_sec);
        end
        pulse_clear();
    endtask

    task automatic test_clear_stop;
        load_time(7'd0, 6'd5);
        clear = 1'b1; start = 1'b1;
        step(1);
        clear = 1'b0; start = 1'b0;
        n_tests++;
        if ({cooking, paused, done, magnetron_en, rem_min, rem_sec} !== 17'd0) begin
            n_fail++; $display("FAIL clear_over_start: got %b %0d:%0d required 0000 0:0", {cooking, paused, done, magnetron_en}, rem_min, rem_sec);
        end
        load_time(7'd0, 6'd5);
        pulse_start();
        step(2);
        pulse_stop();
        n_tests++;
        if ({cooking, paused, done, magnetron_en, rem_min, rem_sec} !== {4'b0100, 7'd0, 6'd5}) begin
            n_fail++; $display("FAIL stop_pause: got %b %0d:%0d required 0100 0:5", {cooking, paused, done, magnetron_en}, rem_min, rem_sec);
        end
        step(1);
        pulse_stop();
        n_tests++;
        if ({cooking, paused, done, magnetron_en, rem_min, rem_sec} !== 17'd0) begin
            n_fail++; $display("FAIL stop_idle: got %b %0d:%0d required 0000 0:0", {cooking, paused, done, magnetron_en}, rem_min, rem_sec);
        end
        load_time(7'd0, 6'd5);
        pulse_start();
        step(2);
        reset = 1'b1;
        #2;
        n_tests++;
        if ({magnetron_en, cooking, paused, done, rem_min, rem_sec} !== 17'd0) begin
            n_fail++; $display("FAIL async_reset: got %h required 0", {magnetron_en, cooking, paused, done, rem_min, rem_sec});
        end
        step(1);
        reset = 1'b0;
        step(1);
        n_tests++;
        if ({magnetron_en, cooking, paused, done, rem_min, rem_sec} !== 17'd0) begin
            n_fail++; $display("FAIL reset_time_lost: got %h required 0", {magnetron_en, cooking, paused, done, rem_min, rem_sec});
        end
    endtask

    task automatic test_quick;
        power_level = 4'd1;
        pulse_start();
`ifdef QUICK_START_EN
        n_tests++;
        if ({cooking, paused, done, magnetron_en, rem_min, rem_sec} !== {4'b1001, 7'd0, 6'd30}) begin
            n_fail++; $display("FAIL quick_start: got %b %0d:%0d required 1001 0:30", {cooking, paused, done, magnetron_en}, rem_min, rem_sec);
        end
        step(8);
        n_tests++;
        if ({magnetron_en, rem_min, rem_sec} !== {1'b1, 7'd0, 6'd28}) begin
            n_fail++; $display("FAIL quick_power: got m=%b %0d:%0d required m=1 0:28", magnetron_en, rem_min, rem_sec);
        end
`else
        n_tests++;
        if ({cooking, paused, done, magnetron_en, rem_min, rem_sec} !== 17'd0) begin
            n_fail++; $display("FAIL zero_start_ignored: got %b %0d:%0d required 0000 0:0", {cooking, paused, done, magnetron_en}, rem_min, rem_sec);
        end
`endif
        pulse_clear();
        power_level = 4'd10;
        step(1);
        load_time(7'd99, 6'd50);
        pulse_start();
        step(1);
        pulse_start();
`ifdef QUICK_START_EN
        exp_q.push_back({7'd99, 6'd59});
`else
        exp_q.push_back({7'd99, 6'd50});
`endif
        n_tests++; exp_t = exp_q.pop_front();
        if ({cooking, rem_min, rem_sec} !== {1'b1, exp_t}) begin
            n_fail++; $display("FAIL cook_start: got c=%b %0d:%0d required c=1 %0d:%0d", cooking, rem_min, rem_sec, exp_t[12:6], exp_t[5:0]);
        end
        pulse_clear();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; time_load = 1'b0;
        door_closed = 1'b1; load_min = '0; load_sec = '0; power_level = 4'd10;
        test_reset();
        test_countdown();
        test_borrow_clamp();
        test_duty();
        test_door();
        test_clear_stop();
        test_quick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
